// File: rtl/fp_mul_normalize_pipe_if.sv
// Handshake and data bundle between the FP32 multiply stage and its normalize/round back end.
// master drives the operation beat; slave (the pipeline) returns the packed result and flags.
// No backpressure: ready is a one-cycle result strobe, not a flow-control signal.
interface fp_mul_normalize_pipe_if;
  logic        valid;
  logic [47:0] M_mul;
  logic [7:0]  E_mul;
  logic [30:0] float_in_2;
  logic        error_in;
  logic [30:0] float_out;
  logic [30:0] float_out_2;
  logic        ready;
  logic        error_out;
  logic        overflow;
  logic        underflow;

  modport master (
    output valid, M_mul, E_mul, float_in_2, error_in,
    input  float_out, float_out_2, ready, error_out, overflow, underflow
  );

  modport slave (
    input  valid, M_mul, E_mul, float_in_2, error_in,
    output float_out, float_out_2, ready, error_out, overflow, underflow
  );
endinterface

// File: rtl/fp_mul_normalize_pipe.sv
// FP32 multiplier back end: normalize, round (RNE, or truncate), re-bias and pack a 31-bit magnitude.
// Latency 2 cycles, full throughput; a beat in cycle t shows ready=1 in cycle t+2.
// No backpressure; optional FP_MUL_ROUND_EN selects round-to-nearest-even, otherwise truncation.
module fp_mul_normalize_pipe #(
  parameter int EXP_BIAS = 127
) (
  input  logic                        clk,
  input  logic                        rst_n,
  fp_mul_normalize_pipe_if.slave      bus
);

  localparam logic signed [9:0] BIAS10 = 10'(EXP_BIAS);

  // Stage 1 registers. The hidden bit is not stored: for legal inputs it is always 1.
  logic               s1_vld;
  logic [22:0]        s1_man;
  logic signed [9:0]  s1_exp;
  logic               s1_err;
  logic [30:0]        s1_f2;
`ifdef FP_MUL_ROUND_EN
  logic               s1_guard;
  logic               s1_sticky;
`endif

  logic [22:0]        n_man;
  logic signed [9:0]  n_exp;
`ifdef FP_MUL_ROUND_EN
  logic               n_guard;
  logic               n_sticky;
`endif

  // Normalize: pick the 24-bit window below the leading one and re-bias the exponent.
  always_comb begin
    n_man = bus.M_mul[45:23];
    n_exp = {{2{bus.E_mul[7]}}, bus.E_mul} + BIAS10;
`ifdef FP_MUL_ROUND_EN
    n_guard  = bus.M_mul[22];
    n_sticky = |bus.M_mul[21:0];
`endif
    if (bus.M_mul[47]) begin
      n_man = bus.M_mul[46:24];
      n_exp = {{2{bus.E_mul[7]}}, bus.E_mul} + BIAS10 + 10'sd1;
`ifdef FP_MUL_ROUND_EN
      n_guard  = bus.M_mul[23];
      n_sticky = |bus.M_mul[22:0];
`endif
    end
  end

  // Stage 1 register: valid bit always tracks input; data only loads on a valid beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld    <= 1'b0;
      s1_man    <= '0;
      s1_exp    <= '0;
      s1_err    <= 1'b0;
      s1_f2     <= '0;
`ifdef FP_MUL_ROUND_EN
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
`endif
    end else begin
      s1_vld <= bus.valid;
      if (bus.valid) begin
        s1_man    <= n_man;
        s1_exp    <= n_exp;
        s1_err    <= bus.error_in;
        s1_f2     <= bus.float_in_2;
`ifdef FP_MUL_ROUND_EN
        s1_guard  <= n_guard;
        s1_sticky <= n_sticky;
`endif
      end
    end
  end

  logic [22:0]        r_man;
  logic signed [9:0]  r_exp;
  logic               r_ovf;
  logic               r_unf;
  logic [30:0]        r_pack;
`ifdef FP_MUL_ROUND_EN
  logic               r_inc;
  logic               r_carry;
`endif

  // Round and classify. A carry out of the fraction means 1.111..1 rounded up to 10.0,
  // which leaves a zero fraction and bumps the exponent; range checks see the bumped value.
  always_comb begin
`ifdef FP_MUL_ROUND_EN
    r_inc            = s1_guard & (s1_sticky | s1_man[0]);
    {r_carry, r_man} = {1'b0, s1_man} + {23'd0, r_inc};
    r_exp            = r_carry ? (s1_exp + 10'sd1) : s1_exp;
`else
    r_man = s1_man;
    r_exp = s1_exp;
`endif
    r_ovf  = (r_exp >= 10'sd255);
    r_unf  = (r_exp <= 10'sd0);
    r_pack = {r_exp[7:0], r_man};
    if (r_ovf) begin
      r_pack = {8'hFF, 23'd0};
    end else if (r_unf) begin
      r_pack = '0;
    end
  end

  // Output register: strobes are zero on idle cycles, data buses hold their last result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ready       <= 1'b0;
      bus.error_out   <= 1'b0;
      bus.overflow    <= 1'b0;
      bus.underflow   <= 1'b0;
      bus.float_out   <= '0;
      bus.float_out_2 <= '0;
    end else begin
      bus.ready     <= s1_vld;
      bus.error_out <= s1_vld & s1_err;
      bus.overflow  <= s1_vld & r_ovf;
      bus.underflow <= s1_vld & r_unf;
      if (s1_vld) begin
        bus.float_out   <= r_pack;
        bus.float_out_2 <= s1_f2;
      end
    end
  end

endmodule

// File: doc/fp_mul_normalize_pipe.md
Name: fp_mul_normalize_pipe

Overview:
- Back-end stage of the FP32 multiplier. Consumes the raw 48-bit significand product and the unbiased exponent sum from the multiply stage.
- Normalizes, rounds and re-biases them, then emits a packed 31-bit magnitude float (sign handled outside). Range errors are flagged.
- Two-stage pipeline. Passes the second operand through for the Newton iteration of the inverse-sqrt datapath.

Parameters:
- EXP_BIAS, 127: exponent bias added to the normalized unbiased exponent.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- valid  in  1  input beat qualifier, one operation per high cycle
- M_mul  in  48  unsigned product {1,M1}*{1,M2}; bit 47 or bit 46 is set for legal inputs
- E_mul  in  8  signed unbiased exponent sum E1+E2
- float_in_2  in  31  operand passed through, aligned with result
- error_in  in  1  upstream error, passed through
- float_out  out  31  {exp[7:0], mant[22:0]} result
- float_out_2  out  31  float_in_2 delayed to align with float_out
- ready  out  1  result valid, one-cycle pulse per input beat
- error_out  out  1  error_in aligned with float_out
- overflow  out  1  result saturated to infinity
- underflow  out  1  result flushed to zero

Behaviour:
- Reset (async, rst_n=0): all outputs and all internal stage registers/valid bits go to 0 immediately. Reset mid-operation discards in-flight beats; no ready pulse follows deassertion.
- Latency: fixed 2 cycles. A valid beat sampled at edge N appears with ready=1 after edge N+2. Full throughput: back-to-back valid gives back-to-back ready. No backpressure.
- Stage 1 (normalize):
  - If M_mul[47]=1: sig=M[47:24], guard=M[23], sticky=|M[22:0], exponent adjust +1.
  - Else: sig=M[46:23], guard=M[22], sticky=|M[21:0], adjust 0.
  - Exponent arithmetic is 10-bit signed: e = sext(E_mul) + adjust + EXP_BIAS.
- Stage 2 (round/pack):
  - Round-to-nearest-even: increment sig when guard & (sticky | sig[0]).
  - Increment carrying out of 24 bits gives sig=0x800000 and e+1.
  - Then: e>=255 gives float_out=0x7F800000, overflow=1. e<=0 gives float_out=0, underflow=1. Otherwise float_out={e[7:0], sig[22:0]}.
  - Overflow and underflow are mutually exclusive. They are computed after the rounding carry.
- Idle cycles: a stage whose valid bit is 0 holds its data registers.
  - Output-side idle: ready=0, error_out=0, overflow=0, underflow=0.
  - float_out and float_out_2 hold their last values.
- error_in does not suppress computation. It only travels with the beat.
- M_mul with bits 47 and 46 both 0 is illegal. The output is unspecified, but the pipeline must not lock up and must not corrupt adjacent beats.

Optional Feature:
- FP_MUL_ROUND_EN
  - Defined: round-to-nearest-even as above.
  - Undefined: truncation. guard/sticky are ignored, no increment, no carry path. Overflow/underflow use the unrounded e. Latency stays 2 cycles.

Test Plan:
- 1.0*1.0: M_mul=0x400000000000, E_mul=0, valid one cycle -> 2 cycles later ready=1, float_out=0x3F800000, flags 0.
- 1.5*1.5: M_mul=0x900000000000, E_mul=0 -> float_out=0x40100000 (bit-47 path).
- Rounding, with ROUND_EN:
  - M_mul=0x400000400000 (tie, even) -> 0x3F800000.
  - M_mul=0x400000C00000 -> 0x3F800002.
  - M_mul=0x7FFFFFC00000 (carry-out) -> 0x40000000.
  - Without ROUND_EN, the same inputs give 0x3F800000, 0x3F800001 and 0x3FFFFFFF respectively.
- Range: E_mul=127 with M_mul=0x900000000000 -> 0x7F800000, overflow=1. E_mul=-127 (0x81) with M_mul=0x400000000000 -> 0x00000000, underflow=1.
- Streaming and reset:
  - Four back-to-back beats with error_in=1 on beat 2 and distinct float_in_2 values -> four consecutive ready cycles, error_out high only on the 2nd, float_out_2 matches per beat.
  - rst_n low for one cycle while 2 beats are in flight -> all outputs 0 at once, no ready afterward until a new valid.
